// File: rtl/main_fsm_if.sv
// Control bundle between the multicycle main FSM and the datapath.
// The master side sequences the instruction and the slave side executes it.
interface main_fsm_if;
  logic [1:0] op;
  logic       funct_5;
  logic       funct_0;
  logic       mem_ready;
  logic       ir_w;
  logic       next_pc;
  logic       branch;
  logic       reg_w;
  logic       mem_w;
  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       alu_op;
  logic [3:0] state;

  modport master (
    input  op, funct_5, funct_0, mem_ready,
    output ir_w, next_pc, branch, reg_w, mem_w,
    output adr_src, alu_src_a, alu_src_b,
    output result_src, alu_op, state
  );

  modport slave (
    output op, funct_5, funct_0, mem_ready,
    input  ir_w, next_pc, branch, reg_w, mem_w,
    input  adr_src, alu_src_a, alu_src_b,
    input  result_src, alu_op, state
  );
endinterface

// File: rtl/main_fsm.sv
// Multicycle ARM main controller: sequences one instruction
// over 3-5 cycles and emits raw datapath control strobes.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  main_fsm_if.master bus
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;

  logic [3:0] state_q;
  logic [3:0] state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          2'b00:   state_d = bus.funct_5 ? EXECUTEI
                                         : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = bus.funct_0 ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = bus.mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: state_d = bus.mem_ready ? FETCH : MEMWRITE;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  // Reset masks everything, including the mem_ready-driven strobes.
  always_comb begin
    bus.ir_w       = 1'b0;
    bus.next_pc    = 1'b0;
    bus.branch     = 1'b0;
    bus.reg_w      = 1'b0;
    bus.mem_w      = 1'b0;
    bus.adr_src    = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.result_src = 2'b00;
    bus.alu_op     = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          bus.alu_src_a  = 1'b1;
          bus.alu_src_b  = 2'b10;
          bus.result_src = 2'b10;
          bus.ir_w       = bus.mem_ready;
          bus.next_pc    = bus.mem_ready;
        end
        DECODE: begin
          bus.alu_src_a  = 1'b1;
          bus.alu_src_b  = 2'b10;
          bus.result_src = 2'b10;
        end
        MEMADR:   bus.alu_src_b = 2'b01;
        MEMREAD:  bus.adr_src = 1'b1;
        MEMWB: begin
          bus.result_src = 2'b01;
          bus.reg_w      = 1'b1;
        end
        MEMWRITE: begin
          bus.adr_src = 1'b1;
          bus.mem_w   = 1'b1;
        end
        EXECUTER: bus.alu_op = 1'b1;
        EXECUTEI: begin
          bus.alu_src_b = 2'b01;
          bus.alu_op    = 1'b1;
        end
        ALUWB:    bus.reg_w = 1'b1;
        BRANCH: begin
          bus.alu_src_b  = 2'b01;
          bus.result_src = 2'b10;
          bus.branch     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed-vector bench for main_fsm: walks every instruction
// class cycle by cycle against hand-derived state/control words.
module tb_main_fsm;

  logic clk = 1'b0;
  logic reset;

  main_fsm_if bus ();

  main_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Control word: {ir_w,next_pc,branch,reg_w,mem_w,adr_src,
  //   alu_src_a,alu_src_b[1:0],result_src[1:0],alu_op}
  localparam logic [11:0] W_IDLE  = 12'h000;
  localparam logic [11:0] W_FET   = 12'hC34;
  localparam logic [11:0] W_FSTL  = 12'h034;
  localparam logic [11:0] W_DEC   = 12'h034;
  localparam logic [11:0] W_MADR  = 12'h008;
  localparam logic [11:0] W_MRD   = 12'h040;
  localparam logic [11:0] W_MWB   = 12'h102;
  localparam logic [11:0] W_MWR   = 12'h0C0;
  localparam logic [11:0] W_EXR   = 12'h001;
  localparam logic [11:0] W_EXI   = 12'h009;
  localparam logic [11:0] W_AWB   = 12'h100;
  localparam logic [11:0] W_BR    = 12'h20C;

  int n_vec = 0;
  int n_bad = 0;

  logic [11:0] ctl;
  assign ctl = {bus.ir_w, bus.next_pc, bus.branch,
                bus.reg_w, bus.mem_w, bus.adr_src,
                bus.alu_src_a, bus.alu_src_b,
                bus.result_src, bus.alu_op};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag,
                     input logic rst,
                     input logic [1:0] op,
                     input logic f5,
                     input logic f0,
                     input logic mr,
                     input logic [3:0] exp_st,
                     input logic [11:0] exp_ctl);
    reset         = rst;
    bus.op        = op;
    bus.funct_5   = f5;
    bus.funct_0   = f0;
    bus.mem_ready = mr;
    #1;
    chk({tag, ".st"}, 32'(bus.state), 32'(exp_st));
    chk({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.op        = 2'b00;
    bus.funct_5   = 1'b0;
    bus.funct_0   = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc("rst0",   1, 2'b00, 0, 0, 1, 4'd0, W_IDLE);
    // DP immediate
    cyc("dpi_f",  0, 2'b00, 1, 0, 1, 4'd0, W_FET);
    cyc("dpi_d",  0, 2'b00, 1, 0, 1, 4'd1, W_DEC);
    cyc("dpi_x",  0, 2'b00, 1, 0, 1, 4'd7, W_EXI);
    cyc("dpi_wb", 0, 2'b00, 1, 0, 1, 4'd8, W_AWB);
    // LDR, two stall cycles in MEMREAD
    cyc("ldr_f",  0, 2'b01, 0, 1, 1, 4'd0, W_FET);
    cyc("ldr_d",  0, 2'b01, 0, 1, 1, 4'd1, W_DEC);
    cyc("ldr_a",  0, 2'b01, 0, 1, 1, 4'd2, W_MADR);
    cyc("ldr_r0", 0, 2'b01, 0, 1, 0, 4'd3, W_MRD);
    cyc("ldr_r1", 0, 2'b01, 0, 1, 0, 4'd3, W_MRD);
    cyc("ldr_r2", 0, 2'b01, 0, 1, 1, 4'd3, W_MRD);
    cyc("ldr_wb", 0, 2'b01, 0, 1, 1, 4'd4, W_MWB);
    // STR, FETCH stalled one cycle
    cyc("str_f0", 0, 2'b01, 0, 0, 0, 4'd0, W_FSTL);
    cyc("str_f1", 0, 2'b01, 0, 0, 1, 4'd0, W_FET);
    cyc("str_d",  0, 2'b01, 0, 0, 1, 4'd1, W_DEC);
    cyc("str_a",  0, 2'b01, 0, 0, 1, 4'd2, W_MADR);
    cyc("str_w",  0, 2'b01, 0, 0, 1, 4'd5, W_MWR);
    // Branch
    cyc("b_f",    0, 2'b10, 0, 0, 1, 4'd0, W_FET);
    cyc("b_d",    0, 2'b10, 0, 0, 1, 4'd1, W_DEC);
    cyc("b_br",   0, 2'b10, 0, 0, 1, 4'd9, W_BR);
    // Undefined op
    cyc("u_f",    0, 2'b11, 1, 1, 1, 4'd0, W_FET);
    cyc("u_d",    0, 2'b11, 1, 1, 1, 4'd1, W_DEC);
    // DP register
    cyc("dpr_f",  0, 2'b00, 0, 1, 1, 4'd0, W_FET);
    cyc("dpr_d",  0, 2'b00, 0, 1, 1, 4'd1, W_DEC);
    cyc("dpr_x",  0, 2'b00, 0, 1, 1, 4'd6, W_EXR);
    cyc("dpr_wb", 0, 2'b00, 0, 1, 1, 4'd8, W_AWB);
    // STR interrupted by reset while in MEMWRITE
    cyc("rs_f",   0, 2'b01, 0, 0, 1, 4'd0, W_FET);
    cyc("rs_d",   0, 2'b01, 0, 0, 1, 4'd1, W_DEC);
    cyc("rs_a",   0, 2'b01, 0, 0, 1, 4'd2, W_MADR);
    cyc("rs_w",   0, 2'b01, 0, 0, 0, 4'd5, W_MWR);
    cyc("rs_r0",  1, 2'b01, 0, 0, 1, 4'd5, W_IDLE);
    cyc("rs_r1",  1, 2'b01, 0, 0, 1, 4'd0, W_IDLE);
    cyc("rs_f2",  0, 2'b01, 0, 0, 1, 4'd0, W_FET);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
